uart_rx_bridge: RTL and testbench

UART_RX_BRIDGE -- requirements
Module: uart_rx_bridge

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_bridge.sv | 101 ++++++++++
 tb/tb_uart_rx_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive bridge and its FIFO.
package uart_pkg;

    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [2:0] err;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic {
        ARMED,
        WAIT_LOW
    } cap_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO of received UART entries; head reads as zero while empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  rx_entry_t                wr_entry,
    input  logic                     pop,
    output rx_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    rx_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW + 1)'(DEPTH));

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_q] <= wr_entry;
    end

    assign head  = empty ? '0 : mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_bridge.sv
// Captures one entry per receiver frame-complete level into a FIFO, tracking
// overruns and discarded frames.
module uart_rx_bridge
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned ERR_DROP = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_done_flag,
    input  logic [7:0]               rx_data,
    input  logic [2:0]               rx_error_flag,
    input  logic                     rd_ready,
    input  logic                     clear_overrun,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic [2:0]               rd_error,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     overrun_flag,
    output logic [7:0]               drop_count
);

    cap_state_t state_q, state_d;
    logic       capture;
    logic       err_frame, overrun, drop, push, pop;
    logic       overrun_q, overrun_d;
    logic [7:0] drop_q, drop_d;
    rx_entry_t  wr_entry, head;

    // Reset lands in WAIT_LOW so a level already high at release is never captured.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            ARMED: begin
                if (rx_done_flag) begin
                    capture = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!rx_done_flag) state_d = ARMED;
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    assign pop       = rd_valid && rd_ready;
    assign err_frame = (ERR_DROP != 0) && (rx_error_flag != 3'b000);
    assign overrun   = capture && !err_frame && fifo_full && !pop;
    assign push      = capture && !err_frame && !overrun;
    assign drop      = capture && (err_frame || overrun);

    assign wr_entry.err  = rx_error_flag;
    assign wr_entry.data = rx_data;

    always_comb begin
        overrun_d = overrun_q;
        if (overrun)            overrun_d = 1'b1;
        else if (clear_overrun) overrun_d = 1'b0;

        drop_d = drop_q;
        if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= WAIT_LOW;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign rd_valid     = !fifo_empty;
    assign rd_data      = head.data;
    assign rd_error     = head.err;
    assign overrun_flag = overrun_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Directed bench for uart_rx_bridge: one instance keeps errored frames, one discards them.
module tb_uart_rx_bridge;

    localparam int unsigned DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_flag = 1'b0;
    logic [7:0] rx_data = '0;
    logic [2:0] rx_error_flag = '0;
    logic       rd_ready = 1'b0;
    logic       clear_overrun = 1'b0;

    logic       rd_valid, fifo_empty, fifo_full, overrun_flag;
    logic [7:0] rd_data, drop_count;
    logic [2:0] rd_error;
    logic [3:0] fifo_count;

    logic       ed_rd_valid, ed_fifo_empty, ed_fifo_full, ed_overrun_flag;
    logic [7:0] ed_rd_data, ed_drop_count;
    logic [2:0] ed_rd_error;
    logic [3:0] ed_fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    uart_rx_bridge #(.DEPTH(DEPTH), .ERR_DROP(0)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_done_flag  (rx_done_flag),
        .rx_data       (rx_data),
        .rx_error_flag (rx_error_flag),
        .rd_ready      (rd_ready),
        .clear_overrun (clear_overrun),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_error      (rd_error),
        .fifo_count    (fifo_count),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .overrun_flag  (overrun_flag),
        .drop_count    (drop_count)
    );

    uart_rx_bridge #(.DEPTH(DEPTH), .ERR_DROP(1)) dut_ed (
        .clock         (clock),
        .reset         (reset),
        .rx_done_flag  (rx_done_flag),
        .rx_data       (rx_data),
        .rx_error_flag (rx_error_flag),
        .rd_ready      (rd_ready),
        .clear_overrun (clear_overrun),
        .rd_valid      (ed_rd_valid),
        .rd_data       (ed_rd_data),
        .rd_error      (ed_rd_error),
        .fifo_count    (ed_fifo_count),
        .fifo_empty    (ed_fifo_empty),
        .fifo_full     (ed_fifo_full),
        .overrun_flag  (ed_overrun_flag),
        .drop_count    (ed_drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic do_reset();
        rx_done_flag  = 1'b0;
        rd_ready      = 1'b0;
        clear_overrun = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [2:0] err, input int hold);
        rx_data       = data;
        rx_error_flag = err;
        rx_done_flag  = 1'b1;
        repeat (hold) @(negedge clock);
        rx_done_flag  = 1'b0;
        @(negedge clock);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        @(negedge clock);
        rd_ready = 1'b0;
    endtask

    initial begin
        @(negedge clock);

        // Reset state
        do_reset();
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_error", 32'(rd_error), 32'd0);
        check("rst_ovr", 32'(overrun_flag), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);

        // Long level yields exactly one entry, visible one cycle after capture
        rx_data = 8'hA5; rx_error_flag = 3'b000; rx_done_flag = 1'b1;
        @(negedge clock);
        check("lat1_valid", 32'(rd_valid), 32'd1);
        repeat (15) @(negedge clock);
        rx_done_flag = 1'b0;
        @(negedge clock);
        check("long_count", 32'(fifo_count), 32'd1);
        check("long_data", 32'(rd_data), 32'hA5);
        pop_expect("long_pop", 8'hA5);
        check("long_empty", 32'(fifo_empty), 32'd1);
        rd_ready = 1'b1;
        @(negedge clock);
        rd_ready = 1'b0;
        check("empty_pop_count", 32'(fifo_count), 32'd0);

        // Nine frames into a DEPTH=8 FIFO: last one is dropped
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 3'b000, 2);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_flag", 32'(overrun_flag), 32'd1);
        check("ovf_drop", 32'(drop_count), 32'd1);
        for (int i = 1; i <= 8; i++) pop_expect("ovf_drain", 8'(i));
        check("ovf_drained", 32'(fifo_empty), 32'd0 + 32'd1);
        check("ovf_flag_sticky", 32'(overrun_flag), 32'd1);
        clear_overrun = 1'b1;
        @(negedge clock);
        clear_overrun = 1'b0;
        check("ovf_cleared", 32'(overrun_flag), 32'd0);

        // Capture and pop together while full
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 3'b000, 1);
        check("cp_full", 32'(fifo_full), 32'd1);
        rx_data = 8'h55; rx_done_flag = 1'b1; rd_ready = 1'b1;
        @(negedge clock);
        rd_ready = 1'b0;
        check("cp_count", 32'(fifo_count), 32'd8);
        check("cp_ovr", 32'(overrun_flag), 32'd0);
        check("cp_drop", 32'(drop_count), 32'd0);
        rx_done_flag = 1'b0;
        @(negedge clock);
        for (int i = 1; i < 8; i++) pop_expect("cp_drain", 8'h10 + 8'(i));
        pop_expect("cp_last", 8'h55);
        check("cp_empty", 32'(fifo_empty), 32'd1);

        // Errored frame: discarded by ERR_DROP=1, kept with flags by ERR_DROP=0
        do_reset();
        send_frame(8'h3C, 3'b100, 2);
        check("ed_drop", 32'(ed_drop_count), 32'd1);
        check("ed_empty", 32'(ed_fifo_empty), 32'd1);
        check("ed_ovr", 32'(ed_overrun_flag), 32'd0);
        check("ek_valid", 32'(rd_valid), 32'd1);
        check("ek_data", 32'(rd_data), 32'h3C);
        check("ek_error", 32'(rd_error), 32'b100);
        check("ek_drop", 32'(drop_count), 32'd0);

        // Level held high across reset release is ignored until it drops
        rx_data = 8'h77; rx_error_flag = 3'b000; rx_done_flag = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rstmid_empty", 32'(fifo_count), 32'd0);
        rx_done_flag = 1'b0;
        @(negedge clock);
        rx_done_flag = 1'b1;
        @(negedge clock);
        check("rstmid_cap", 32'(fifo_count), 32'd1);
        rx_done_flag = 1'b0;
        @(negedge clock);

        // Overrun coinciding with clear_overrun: set wins
        for (int i = 0; i < 7; i++) send_frame(8'h80 + 8'(i), 3'b000, 1);
        check("set_full", 32'(fifo_full), 32'd1);
        rx_data = 8'h99; rx_done_flag = 1'b1; clear_overrun = 1'b1;
        @(negedge clock);
        clear_overrun = 1'b0; rx_done_flag = 1'b0;
        check("set_wins", 32'(overrun_flag), 32'd1);
        check("set_drop", 32'(drop_count), 32'd1);
        @(negedge clock);

        // drop_count saturates at 255
        for (int i = 0; i < 254; i++) send_frame(8'hEE, 3'b000, 1);
        check("sat_255", 32'(drop_count), 32'd255);
        send_frame(8'hEE, 3'b000, 1);
        check("sat_hold", 32'(drop_count), 32'd255);
        check("sat_count", 32'(fifo_count), 32'd8);
        pop_expect("sat_head", 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
